fcs_check_stream: RTL and testbench
===================================

Name: fcs_check_stream

Overview:
- Parametrised Ethernet FCS (CRC-32) checker. Consumes a DATA_W-bit-per-beat stream with valid/sof/eof framing.
- Emits one result record per frame: FCS error, runt flag, beat length. Also keeps saturating good/bad frame counters.
- Sits on each switch ingress port between the PHY/deserialiser and the frame buffer. Successor to the bit-serial checker.
- Adds wide datapath, explicit valid, per-frame result pulse, runt detection, abort handling and statistics.

Parameters:
- DATA_W, 8, bits per beat; legal range 1..64; every frame length is a multiple of DATA_W.
- MIN_BITS, 512, minimum legal frame length in bits, FCS included; shorter frames flag res_runt.
- LEN_W, 16, width of the beat-length counter.
- CNT_W, 32, width of the good/bad statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  beat qualifier
- in_sof  in  1  beat is first of frame; only meaningful with in_valid
- in_eof  in  1  beat is last of frame (contains last FCS bit); only meaningful with in_valid
- in_data  in  DATA_W  beat data; bit 0 is transmitted first
- res_valid  out  1  one-cycle result strobe
- res_fcs_err  out  1  FCS residue mismatch
- res_runt  out  1  frame shorter than MIN_BITS
- res_aborted  out  1  frame was cut by a new sof before eof
- res_len  out  LEN_W  beats in the reported frame, saturating
- good_cnt  out  CNT_W  frames with no error and no runt, saturating
- bad_cnt  out  CNT_W  frames with fcs_err, runt or abort, saturating

Behaviour:
- Reset: all outputs 0, CRC state 0xFFFFFFFF, FSM in IDLE, length 0.
- CRC per bit b, taken in order bit 0..DATA_W-1 of the beat:
  - fb = S[31]^b
  - S = {S[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0)
  - The whole beat update is one combinational step per cycle.
- FSM states: IDLE, IN_FRAME.
- IDLE:
  - in_valid&in_sof: S = step(0xFFFFFFFF, in_data), len = 1.
  - If in_eof is also set, the frame is single-beat and reports immediately (see result timing). Otherwise go to IN_FRAME.
  - Valid beats without sof are ignored; no state change, no result.
- IN_FRAME:
  - in_valid&!in_sof: S = step(S, in_data); len += 1, saturating at 2^LEN_W-1.
  - in_valid&in_eof: evaluate and go to IDLE.
  - in_valid&in_sof (a restart) does two things in the same cycle:
    - Reports the old frame with res_aborted=1, res_fcs_err=1, res_len = old len.
    - Starts the new frame from this beat. If this beat also has eof, the new frame's result strobes on the following cycle.
  - in_valid low: hold all state (gaps allowed anywhere in a frame).
- Result timing:
  - res_valid is high exactly one cycle after the eof or abort beat; 1-cycle latency, registered outputs.
  - res_fcs_err = (S_final != 32'hC704DD7B).
  - res_runt = (len*DATA_W < MIN_BITS), computed on the unsaturated product against MIN_BITS.
  - res_* fields hold their values until the next strobe.
- Counters: on each strobe, exactly one of good_cnt / bad_cnt increments, saturating at all-ones. good means !err & !runt & !aborted.
- reset mid-frame: frame discarded, no result, counters cleared.
- No backpressure: the block accepts every beat.

Decomposition:
- Package fcs_pkg holds:
  - CRC_POLY = 32'h04C11DB7
  - CRC_INIT = 32'hFFFFFFFF
  - CRC_RESIDUE = 32'hC704DD7B
  - typedef fcs_state_e {IDLE, IN_FRAME}
  - typedef crc_t = logic[31:0]
- Sub-module crc32_step: purely combinational, parameter DATA_W, ports crc_in/data_in/crc_out. Implements the DATA_W-bit unrolled update. Reusable by the future FCS generator on egress.

Test Plan:
- DATA_W=8, MIN_BITS=64: frame bytes "123456789" (0x31..0x39) then 0x26,0x39,0xF4,0xCB, sof on first beat, eof on last -> res_valid 1 cycle after eof, res_fcs_err=0, res_runt=0, res_len=13, good_cnt=1.
- Same frame with byte 0x35 changed to 0x34 -> res_fcs_err=1, bad_cnt=1, good_cnt=0.
- DATA_W=8, MIN_BITS=512: the correct 13-byte frame above -> res_runt=1, res_fcs_err=0, bad_cnt=1.
- DATA_W=1 and DATA_W=32: the same 104-bit frame (for DATA_W=32, zero-padded to 128 bits with recomputed FCS) with random in_valid gaps -> identical res_fcs_err=0 for each width; inserted gaps do not change the result.
- sof at beat 5 of an unfinished frame, then a complete good frame -> first strobe res_aborted=1, res_len=4; second strobe good; bad_cnt=1, good_cnt=1.
- CNT_W=2: 5 good frames -> good_cnt saturates at 3. Assert reset mid-frame -> no strobe, all outputs 0, next good frame reported correctly.

Source files
------------

// File: rtl/fcs_pkg.sv
// Shared CRC-32 constants and types for the Ethernet FCS checker and generator.
package fcs_pkg;

    typedef logic [31:0] crc_t;

    localparam crc_t CRC_POLY    = 32'h04C11DB7;
    localparam crc_t CRC_INIT    = 32'hFFFFFFFF;
    localparam crc_t CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } fcs_state_e;

endpackage

// File: rtl/crc32_step.sv
// Combinational CRC-32 update over one DATA_W-bit beat, bit 0 of the beat first.
module crc32_step
    import fcs_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  crc_t              crc_in,
    input  logic [DATA_W-1:0] data_in,
    output crc_t              crc_out
);

    crc_t crc_acc;

    always_comb begin
        crc_acc = crc_in;
        for (int i = 0; i < DATA_W; i++) begin
            if (crc_acc[31] ^ data_in[i]) begin
                crc_acc = {crc_acc[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_acc = {crc_acc[30:0], 1'b0};
            end
        end
        crc_out = crc_acc;
    end

endmodule

// File: rtl/fcs_check_stream.sv
// Ethernet FCS checker for a framed DATA_W-bit stream: one registered result
// per frame (FCS error, runt, abort, length) plus saturating good/bad counters.
module fcs_check_stream
    import fcs_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MIN_BITS = 512,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [DATA_W-1:0] in_data,
    output logic              res_valid,
    output logic              res_fcs_err,
    output logic              res_runt,
    output logic              res_aborted,
    output logic [LEN_W-1:0]  res_len,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  bad_cnt
);

    localparam int unsigned     PROD_W  = LEN_W + 32;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fcs_state_e       state_q, state_d;
    crc_t             crc_q, crc_d, crc_seed, crc_next;
    logic [LEN_W-1:0] len_q, len_d, len_inc;
    logic             pend_q, pend_d, pend_err_q, pend_err_d;
    logic             new_v, new_err, abt_v;
    logic [LEN_W-1:0] new_len;
    logic             res_valid_d, res_fcs_err_d, res_runt_d, res_aborted_d;
    logic [LEN_W-1:0] res_len_d;
    logic [CNT_W-1:0] good_cnt_d, bad_cnt_d;

    // Runt test uses the full-width product so it never wraps.
    function automatic logic is_runt(input logic [LEN_W-1:0] l);
        return (PROD_W'(l) * PROD_W'(DATA_W)) < PROD_W'(MIN_BITS);
    endfunction

    assign crc_seed = in_sof ? CRC_INIT : crc_q;
    assign len_inc  = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);

    crc32_step #(.DATA_W(DATA_W)) u_step (
        .crc_in  (crc_seed),
        .data_in (in_data),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        len_d         = len_q;
        pend_d        = 1'b0;
        pend_err_d    = pend_err_q;
        new_v         = 1'b0;
        new_err       = 1'b0;
        new_len       = len_q;
        abt_v         = 1'b0;
        res_valid_d   = 1'b0;
        res_fcs_err_d = res_fcs_err;
        res_runt_d    = res_runt;
        res_aborted_d = res_aborted;
        res_len_d     = res_len;
        good_cnt_d    = good_cnt;
        bad_cnt_d     = bad_cnt;

        case (state_q)
            IDLE: begin
                if (in_valid && in_sof) begin
                    crc_d = crc_next;
                    len_d = LEN_W'(1);
                    if (in_eof) begin
                        new_v   = 1'b1;
                        new_err = (crc_next != CRC_RESIDUE);
                        new_len = LEN_W'(1);
                    end else begin
                        state_d = IN_FRAME;
                    end
                end
            end
            IN_FRAME: begin
                if (in_valid && in_sof) begin
                    // Restart: abort the old frame and open a new one on this beat.
                    abt_v = 1'b1;
                    crc_d = crc_next;
                    len_d = LEN_W'(1);
                    if (in_eof) begin
                        pend_d     = 1'b1;
                        pend_err_d = (crc_next != CRC_RESIDUE);
                        state_d    = IDLE;
                    end
                end else if (in_valid) begin
                    crc_d = crc_next;
                    len_d = len_inc;
                    if (in_eof) begin
                        new_v   = 1'b1;
                        new_err = (crc_next != CRC_RESIDUE);
                        new_len = len_inc;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A deferred single-beat result goes first; a colliding new one waits a cycle.
        if (abt_v) begin
            res_valid_d   = 1'b1;
            res_fcs_err_d = 1'b1;
            res_runt_d    = is_runt(len_q);
            res_aborted_d = 1'b1;
            res_len_d     = len_q;
        end else if (pend_q) begin
            res_valid_d   = 1'b1;
            res_fcs_err_d = pend_err_q;
            res_runt_d    = is_runt(LEN_W'(1));
            res_aborted_d = 1'b0;
            res_len_d     = LEN_W'(1);
            if (new_v) begin
                pend_d     = 1'b1;
                pend_err_d = new_err;
            end
        end else if (new_v) begin
            res_valid_d   = 1'b1;
            res_fcs_err_d = new_err;
            res_runt_d    = is_runt(new_len);
            res_aborted_d = 1'b0;
            res_len_d     = new_len;
        end

        if (res_valid_d) begin
            if (!res_fcs_err_d && !res_runt_d && !res_aborted_d) begin
                if (good_cnt != CNT_MAX) good_cnt_d = good_cnt + CNT_W'(1);
            end else begin
                if (bad_cnt != CNT_MAX) bad_cnt_d = bad_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            crc_q       <= CRC_INIT;
            len_q       <= '0;
            pend_q      <= 1'b0;
            pend_err_q  <= 1'b0;
            res_valid   <= 1'b0;
            res_fcs_err <= 1'b0;
            res_runt    <= 1'b0;
            res_aborted <= 1'b0;
            res_len     <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            pend_q      <= pend_d;
            pend_err_q  <= pend_err_d;
            res_valid   <= res_valid_d;
            res_fcs_err <= res_fcs_err_d;
            res_runt    <= res_runt_d;
            res_aborted <= res_aborted_d;
            res_len     <= res_len_d;
            good_cnt    <= good_cnt_d;
            bad_cnt     <= bad_cnt_d;
        end
    end

endmodule

// File: tb/tb_fcs_check_stream.sv
// Directed bench for fcs_check_stream at 8-, 1- and 32-bit beat widths.
module tb_fcs_check_stream;

    logic clk, reset;
    logic v8, s8, e8;  logic [7:0]  d8;
    logic v1, s1, e1;  logic        d1;
    logic v32, s32, e32; logic [31:0] d32;

    logic a_valid, a_err, a_runt, a_abort; logic [15:0] a_len; logic [1:0]  a_good, a_bad;
    logic r_valid, r_err, r_runt, r_abort; logic [15:0] r_len; logic [31:0] r_good, r_bad;
    logic o_valid, o_err, o_runt, o_abort; logic [15:0] o_len; logic [31:0] o_good, o_bad;
    logic w_valid, w_err, w_runt, w_abort; logic [15:0] w_len; logic [31:0] w_good, w_bad;

    int checks = 0;
    int passes = 0;
    logic [7:0] fr[$];
    logic [7:0] good13[$];
    logic [7:0] fw[$];
    logic [31:0] fcs;

    fcs_check_stream #(.DATA_W(8), .MIN_BITS(64), .LEN_W(16), .CNT_W(2)) u_a (
        .clk(clk), .reset(reset), .in_valid(v8), .in_sof(s8), .in_eof(e8), .in_data(d8),
        .res_valid(a_valid), .res_fcs_err(a_err), .res_runt(a_runt), .res_aborted(a_abort),
        .res_len(a_len), .good_cnt(a_good), .bad_cnt(a_bad));

    fcs_check_stream #(.DATA_W(8), .MIN_BITS(512), .LEN_W(16), .CNT_W(32)) u_r (
        .clk(clk), .reset(reset), .in_valid(v8), .in_sof(s8), .in_eof(e8), .in_data(d8),
        .res_valid(r_valid), .res_fcs_err(r_err), .res_runt(r_runt), .res_aborted(r_abort),
        .res_len(r_len), .good_cnt(r_good), .bad_cnt(r_bad));

    fcs_check_stream #(.DATA_W(1), .MIN_BITS(64), .LEN_W(16), .CNT_W(32)) u_1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_sof(s1), .in_eof(e1), .in_data(d1),
        .res_valid(o_valid), .res_fcs_err(o_err), .res_runt(o_runt), .res_aborted(o_abort),
        .res_len(o_len), .good_cnt(o_good), .bad_cnt(o_bad));

    fcs_check_stream #(.DATA_W(32), .MIN_BITS(64), .LEN_W(16), .CNT_W(32)) u_w (
        .clk(clk), .reset(reset), .in_valid(v32), .in_sof(s32), .in_eof(e32), .in_data(d32),
        .res_valid(w_valid), .res_fcs_err(w_err), .res_runt(w_runt), .res_aborted(w_abort),
        .res_len(w_len), .good_cnt(w_good), .bad_cnt(w_bad));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference CRC in the reflected (LSB-first) form; a good frame leaves 0xDEBB20E3.
    function automatic logic [31:0] crc_ref(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic exp_err(input logic [7:0] q[$]);
        return crc_ref(q) != 32'hDEBB20E3;
    endfunction

    task automatic drive8(input logic v, input logic s, input logic e, input logic [7:0] d);
        @(negedge clk);
        v8 = v; s8 = s; e8 = e; d8 = d;
    endtask

    // Sends fr as one frame; returns at the negedge where the result is visible.
    task automatic send8();
        for (int i = 0; i < fr.size(); i++) drive8(1'b1, i == 0, i == fr.size() - 1, fr[i]);
        drive8(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic send1(input int gap_max);
        int nb;
        nb = fr.size() * 8;
        for (int j = 0; j < nb; j++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(negedge clk); v1 = 1'b0; s1 = 1'b0; e1 = 1'b0; d1 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            v1 = 1'b1; s1 = (j == 0); e1 = (j == nb - 1); d1 = fr[j / 8][j % 8];
        end
        @(negedge clk); v1 = 1'b0; s1 = 1'b0; e1 = 1'b0; d1 = 1'b0;
    endtask

    task automatic send32(input int gap_max);
        int nw;
        nw = fw.size() / 4;
        for (int k = 0; k < nw; k++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(negedge clk); v32 = 1'b0; s32 = 1'b0; e32 = 1'b0; d32 = $urandom;
            end
            @(negedge clk);
            v32 = 1'b1; s32 = (k == 0); e32 = (k == nw - 1);
            d32 = {fw[4*k+3], fw[4*k+2], fw[4*k+1], fw[4*k]};
        end
        @(negedge clk); v32 = 1'b0; s32 = 1'b0; e32 = 1'b0; d32 = '0;
    endtask

    initial begin
        good13 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};
        reset = 1'b1;
        v8 = 0; s8 = 0; e8 = 0; d8 = 0;
        v1 = 0; s1 = 0; e1 = 0; d1 = 0;
        v32 = 0; s32 = 0; e32 = 0; d32 = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", a_valid, 0);
        check("rst_len",   a_len, 0);
        check("rst_good",  a_good, 0);
        check("rst_bad",   a_bad, 0);
        reset = 1'b0;

        // Good "123456789" frame with its FCS
        fr = good13;
        send8();
        check("good_valid", a_valid, 1);
        check("good_err",   a_err, 0);
        check("good_runt",  a_runt, 0);
        check("good_len",   a_len, 13);
        check("good_gcnt",  a_good, 1);
        check("good_bcnt",  a_bad, 0);
        check("runt512_runt", r_runt, 1);
        check("runt512_err",  r_err, 0);
        check("runt512_bcnt", r_bad, 1);
        check("runt512_gcnt", r_good, 0);
        @(negedge clk);
        check("strobe_1cyc", a_valid, 0);
        check("hold_len",    a_len, 13);

        // Corrupted byte
        pulse_reset();
        fr = good13; fr[4] = 8'h34;
        send8();
        check("bad_valid", a_valid, 1);
        check("bad_err",   a_err, 1);
        check("bad_bcnt",  a_bad, 1);
        check("bad_gcnt",  a_good, 0);

        // Abort by sof on beat 5, then a good frame
        pulse_reset();
        for (int i = 0; i < 4; i++) drive8(1'b1, i == 0, 1'b0, good13[i]);
        for (int i = 0; i < 13; i++) begin
            drive8(1'b1, i == 0, i == 12, good13[i]);
            if (i == 1) begin
                check("abort_valid", a_valid, 1);
                check("abort_flag",  a_abort, 1);
                check("abort_err",   a_err, 1);
                check("abort_len",   a_len, 4);
            end
        end
        drive8(1'b0, 1'b0, 1'b0, 8'h00);
        check("after_abort_valid", a_valid, 1);
        check("after_abort_flag",  a_abort, 0);
        check("after_abort_err",   a_err, 0);
        check("after_abort_len",   a_len, 13);
        check("after_abort_gcnt",  a_good, 1);
        check("after_abort_bcnt",  a_bad, 1);

        // Restart on a sof+eof beat: abort now, single-beat result next cycle
        pulse_reset();
        drive8(1'b1, 1'b1, 1'b0, 8'h31);
        drive8(1'b1, 1'b0, 1'b0, 8'h32);
        drive8(1'b1, 1'b1, 1'b1, 8'h00);
        drive8(1'b0, 1'b0, 1'b0, 8'h00);
        check("rs_abort_flag", a_abort, 1);
        check("rs_abort_len",  a_len, 2);
        fr = '{8'h00};
        @(negedge clk);
        check("rs_single_valid", a_valid, 1);
        check("rs_single_abort", a_abort, 0);
        check("rs_single_len",   a_len, 1);
        check("rs_single_runt",  a_runt, 1);
        check("rs_single_err",   a_err, exp_err(fr));
        check("rs_bcnt",         a_bad, 2);

        // Counter saturation at CNT_W=2
        pulse_reset();
        fr = good13;
        repeat (5) send8();
        check("sat_gcnt",   a_good, 3);
        check("sat_bcnt",   a_bad, 0);
        check("r_bcnt_5",   r_bad, 5);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) drive8(1'b1, i == 0, 1'b0, good13[i]);
        @(negedge clk); v8 = 0; s8 = 0; e8 = 0; reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", a_valid, 0);
        check("midrst_len",   a_len, 0);
        check("midrst_gcnt",  a_good, 0);
        check("midrst_err",   a_err, 0);
        reset = 1'b0;
        send8();
        check("post_rst_valid", a_valid, 1);
        check("post_rst_err",   a_err, 0);
        check("post_rst_len",   a_len, 13);
        check("post_rst_gcnt",  a_good, 1);

        // 1-bit beats, without and with gaps
        fr = good13;
        send1(0);
        check("w1_valid", o_valid, 1);
        check("w1_err",   o_err, 0);
        check("w1_len",   o_len, 104);
        check("w1_runt",  o_runt, 0);
        send1(2);
        check("w1_gap_valid", o_valid, 1);
        check("w1_gap_err",   o_err, 0);
        check("w1_gap_gcnt",  o_good, 2);

        // 32-bit beats: zero-padded 12-byte payload with recomputed FCS
        fw = {};
        for (int i = 0; i < 9; i++) fw.push_back(good13[i]);
        repeat (3) fw.push_back(8'h00);
        fcs = ~crc_ref(fw);
        for (int i = 0; i < 4; i++) fw.push_back(fcs[8*i +: 8]);
        send32(2);
        check("w32_valid", w_valid, 1);
        check("w32_err",   w_err, 0);
        check("w32_len",   w_len, 4);
        check("w32_runt",  w_runt, 0);
        fw[2] = fw[2] ^ 8'h01;
        send32(2);
        check("w32_bad_err",  w_err, 1);
        check("w32_bad_bcnt", w_bad, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
